// File: rtl/prga_decrypt_fsm.sv
// RC4 PRGA stage: walks S with i/j, swaps S[i]/S[j] in place, fetches the
// keystream byte S[S[i]+S[j]] and writes ct ^ keystream to plaintext RAM.
//
// state        | meaning
// IDLE         | waiting for start; i, j, k cleared on launch
// INC_I        | i <= i + 1
// RD_SI        | present i to S
// STR_SI_J     | capture S[i], j <= j + S[i]
// RD_SJ        | present j to S
// STR_SJ_WR_SI | capture S[j], write S[j] <= si
// WR_SJ        | write S[i] <= sj
// RD_F         | present si + sj to S (post-swap contents)
// STR_F        | capture keystream byte and ciphertext byte
// WR_PT        | write plaintext byte, k <= k + 1
// CHECK_K      | done after MSG_LEN bytes, else next byte
// DONE         | one-cycle completion pulse
module prga_decrypt_fsm #(
  parameter int MSG_LEN = 32,
  localparam int KW = $clog2(MSG_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [7:0]    s_addr,
  output logic [7:0]    s_wrdata,
  output logic          s_wren,
  input  logic [7:0]    s_rddata,
  output logic [KW-1:0] ct_addr,
  input  logic [7:0]    ct_rddata,
  output logic [KW-1:0] pt_addr,
  output logic [7:0]    pt_wrdata,
  output logic          pt_wren,
  output logic          fsm_on,
  output logic          fin_strobe
);

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_INC_I        = 4'd1,
    ST_RD_SI        = 4'd2,
    ST_STR_SI_J     = 4'd3,
    ST_RD_SJ        = 4'd4,
    ST_STR_SJ_WR_SI = 4'd5,
    ST_WR_SJ        = 4'd6,
    ST_RD_F         = 4'd7,
    ST_STR_F        = 4'd8,
    ST_WR_PT        = 4'd9,
    ST_CHECK_K      = 4'd10,
    ST_DONE         = 4'd11
  } state_t;

  localparam logic [KW-1:0] K_LAST = KW'(MSG_LEN);

  state_t state, state_nxt;
  logic [7:0]    i, j, si, sj, f, ct;
  logic [KW-1:0] k;

  assign ct_addr = k;
  assign pt_addr = k;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and output decode; all outputs depend on state and registers only
  always_comb begin
    state_nxt  = ST_IDLE;
    s_addr     = 8'd0;
    s_wrdata   = 8'd0;
    s_wren     = 1'b0;
    pt_wrdata  = 8'd0;
    pt_wren    = 1'b0;
    fin_strobe = 1'b0;
    fsm_on     = (state != ST_IDLE) && (state != ST_DONE);
    case (state)
      ST_IDLE:         state_nxt = start ? ST_INC_I : ST_IDLE;
      ST_INC_I:        state_nxt = ST_RD_SI;
      ST_RD_SI: begin
        s_addr    = i;
        state_nxt = ST_STR_SI_J;
      end
      ST_STR_SI_J:     state_nxt = ST_RD_SJ;
      ST_RD_SJ: begin
        s_addr    = j;
        state_nxt = ST_STR_SJ_WR_SI;
      end
      ST_STR_SJ_WR_SI: begin
        s_addr    = j;
        s_wrdata  = si;
        s_wren    = 1'b1;
        state_nxt = ST_WR_SJ;
      end
      ST_WR_SJ: begin
        s_addr    = i;
        s_wrdata  = sj;
        s_wren    = 1'b1;
        state_nxt = ST_RD_F;
      end
      ST_RD_F: begin
        s_addr    = si + sj;
        state_nxt = ST_STR_F;
      end
      ST_STR_F:        state_nxt = ST_WR_PT;
      ST_WR_PT: begin
        pt_wrdata = f ^ ct;
        pt_wren   = 1'b1;
        state_nxt = ST_CHECK_K;
      end
      ST_CHECK_K:      state_nxt = (k == K_LAST) ? ST_DONE : ST_INC_I;
      ST_DONE: begin
        fin_strobe = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default:         state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers: indices, swap operands, keystream and ciphertext bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      i  <= 8'd0;
      j  <= 8'd0;
      k  <= '0;
      si <= 8'd0;
      sj <= 8'd0;
      f  <= 8'd0;
      ct <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            i <= 8'd0;
            j <= 8'd0;
            k <= '0;
          end
        end
        ST_INC_I:        i <= i + 8'd1;
        ST_STR_SI_J: begin
          si <= s_rddata;
          j  <= j + s_rddata;
        end
        ST_STR_SJ_WR_SI: sj <= s_rddata;
        ST_STR_F: begin
          f  <= s_rddata;
          ct <= ct_rddata;
        end
        ST_WR_PT:        k <= k + KW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prga_decrypt_fsm.sv
// Bench for prga_decrypt_fsm: S RAM / ciphertext ROM models, a software RC4
// PRGA reference evaluated at launch, and a per-cycle output comparator.
module tb_prga_decrypt_fsm;

  localparam int L  = 260;
  localparam int KW = $clog2(L + 1);

  logic          clk = 1'b0;
  logic          rst, start;
  logic [7:0]    s_addr, s_wrdata, s_rddata;
  logic          s_wren;
  logic [KW-1:0] ct_addr, pt_addr;
  logic [7:0]    ct_rddata, pt_wrdata;
  logic          pt_wren, fsm_on, fin_strobe;

  always #5 clk = ~clk;

  prga_decrypt_fsm #(.MSG_LEN(L)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .s_rddata(s_rddata),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren),
    .fsm_on(fsm_on), .fin_strobe(fin_strobe)
  );

  // Memories: S RAM with a bench load port, ciphertext ROM
  logic [7:0] s_mem [256];
  logic [7:0] ct_mem [512];
  logic [7:0] stim_s [256];
  logic       ld_en;
  logic [7:0] ld_addr, ld_data;

  always @(posedge clk) begin
    if (ld_en)       s_mem[ld_addr] <= ld_data;
    else if (s_wren) s_mem[s_addr]  <= s_wrdata;
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
  end

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model: position within a run (-1 idle, 10*L = DONE) and RC4 results
  int         m_pos = -1;
  logic [7:0] m_s [256];
  logic [7:0] w [256];
  logic [7:0] e_i [L], e_j [L], e_si [L], e_sj [L], e_t [L], e_pt [L], got_pt [L];
  int         cp_off, cp_b, cp_bad;
  logic       cp_busy, cp_xw, cp_xp;
  logic [7:0] cp_xa, cp_xd, cp_xpt, cp_ii, cp_jj;

  // Compare every cycle against the model, then advance the model with the inputs
  always @(negedge clk) begin
    cp_off  = (m_pos >= 0) ? m_pos % 10 : 0;
    cp_b    = (m_pos >= 0) ? m_pos / 10 : 0;
    cp_busy = (m_pos >= 0) && (m_pos < 10 * L);
    cp_xa = 8'd0; cp_xd = 8'd0; cp_xw = 1'b0; cp_xp = 1'b0; cp_xpt = 8'd0;
    if (cp_busy) begin
      case (cp_off)
        1: cp_xa = e_i[cp_b];
        3: cp_xa = e_j[cp_b];
        4: begin cp_xa = e_j[cp_b]; cp_xd = e_si[cp_b]; cp_xw = 1'b1; end
        5: begin cp_xa = e_i[cp_b]; cp_xd = e_sj[cp_b]; cp_xw = 1'b1; end
        6: cp_xa = e_t[cp_b];
        8: begin cp_xp = 1'b1; cp_xpt = e_pt[cp_b]; end
        default: ;
      endcase
    end
    chk("fsm_on", int'(fsm_on), int'(cp_busy));
    chk("fin_strobe", int'(fin_strobe), (m_pos == 10 * L) ? 1 : 0);
    chk("s_wren", int'(s_wren), int'(cp_xw));
    chk("s_addr", int'(s_addr), int'(cp_xa));
    chk("s_wrdata", int'(s_wrdata), int'(cp_xd));
    chk("pt_wren", int'(pt_wren), int'(cp_xp));
    chk("pt_wrdata", int'(pt_wrdata), int'(cp_xpt));
    if (m_pos >= 0) begin
      chk("ct_addr", int'(ct_addr), cp_b + ((cp_off == 9) ? 1 : 0));
      chk("pt_addr", int'(pt_addr), cp_b + ((cp_off == 9) ? 1 : 0));
    end
    if (cp_xp) got_pt[cp_b] = pt_wrdata;

    if (ld_en) m_s[ld_addr] = ld_data;
    if (rst) begin
      m_pos = -1;
    end else if (m_pos < 0) begin
      if (start) begin
        for (int a = 0; a < 256; a++) w[a] = m_s[a];
        cp_ii = 8'd0;
        cp_jj = 8'd0;
        for (int n = 0; n < L; n++) begin
          cp_ii = cp_ii + 8'd1;
          cp_jj = cp_jj + w[cp_ii];
          e_i[n]  = cp_ii;
          e_j[n]  = cp_jj;
          e_si[n] = w[cp_ii];
          e_sj[n] = w[cp_jj];
          w[cp_ii] = e_sj[n];
          w[cp_jj] = e_si[n];
          e_t[n]  = e_si[n] + e_sj[n];
          e_pt[n] = w[e_t[n]] ^ ct_mem[n];
        end
        m_pos = 0;
      end
    end else if (m_pos < 10 * L) begin
      m_pos++;
    end else begin
      cp_bad = 0;
      for (int a = 0; a < 256; a++) if (s_mem[a] != w[a]) cp_bad++;
      chk("final_s_entries_wrong", cp_bad, 0);
      for (int a = 0; a < 256; a++) m_s[a] = w[a];
      m_pos = -1;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load_s();
    for (int a = 0; a < 256; a++) begin
      ld_en = 1'b1; ld_addr = 8'(a); ld_data = stim_s[a];
      step();
    end
    ld_en = 1'b0;
  endtask

  task automatic wait_fin(output int fin_e);
    fin_e = -1;
    for (int c = 0; c < 10 * L + 20; c++) begin
      step();
      if (fin_strobe) begin
        fin_e = ecnt;
        break;
      end
    end
    if (fin_e < 0) chk("fin_timeout", 0, 1);
  endtask

  task automatic run_once(output int launch, output int fin_e);
    start = 1'b1;
    launch = ecnt + 1;
    step();
    start = 1'b0;
    wait_fin(fin_e);
    step();
    step();
  endtask

  int launch, fin1, fin2;

  initial begin
    rst = 1'b1; start = 1'b0; ld_en = 1'b0; ld_addr = 8'd0; ld_data = 8'd0;
    for (int a = 0; a < 512; a++) ct_mem[a] = 8'd0;
    repeat (3) step();
    chk("rst_s_addr", int'(s_addr), 0);
    chk("rst_s_wrdata", int'(s_wrdata), 0);
    chk("rst_s_wren", int'(s_wren), 0);
    chk("rst_ct_addr", int'(ct_addr), 0);
    chk("rst_pt_addr", int'(pt_addr), 0);
    chk("rst_pt_wrdata", int'(pt_wrdata), 0);
    chk("rst_pt_wren", int'(pt_wren), 0);
    chk("rst_fsm_on", int'(fsm_on), 0);
    chk("rst_fin", int'(fin_strobe), 0);
    rst = 1'b0;
    step();

    // Identity S, ct = 0
    for (int a = 0; a < 256; a++) stim_s[a] = 8'(a);
    load_s();
    run_once(launch, fin1);
    chk("id_fin_edge", fin1, launch + 10 * L);
    chk("id_pt0", int'(got_pt[0]), 8'h02);
    chk("id_pt1", int'(got_pt[1]), 8'h05);
    chk("id_pt2", int'(got_pt[2]), 8'h07);
    chk("id_pt3", int'(got_pt[3]), 8'h0D);
    chk("model_pt0", int'(e_pt[0]), 8'h02);
    chk("model_pt3", int'(e_pt[3]), 8'h0D);

    // Identity S, ct = FF
    for (int a = 0; a < 512; a++) ct_mem[a] = 8'hFF;
    load_s();
    run_once(launch, fin1);
    chk("ff_fin_edge", fin1, launch + 10 * L);
    chk("ff_pt0", int'(got_pt[0]), 8'hFD);
    chk("ff_pt1", int'(got_pt[1]), 8'hFA);
    chk("ff_pt2", int'(got_pt[2]), 8'hF8);
    chk("ff_pt3", int'(got_pt[3]), 8'hF2);

    // S all FF, ct = 0: j and si+sj wrap
    for (int a = 0; a < 256; a++) stim_s[a] = 8'hFF;
    for (int a = 0; a < 512; a++) ct_mem[a] = 8'h00;
    load_s();
    run_once(launch, fin1);
    for (int n = 0; n < 8; n++) chk("allff_pt", int'(got_pt[n]), 8'hFF);
    chk("model_j7", int'(e_j[7]), 8'hF8);

    // Random S and ciphertext, i wraps past 255
    for (int a = 0; a < 256; a++) stim_s[a] = 8'($urandom_range(0, 255));
    for (int a = 0; a < 512; a++) ct_mem[a] = 8'($urandom_range(0, 255));
    load_s();
    run_once(launch, fin1);

    // Reset during STR_SJ_WR_SI of byte 2, then a fresh run
    load_s();
    start = 1'b1;
    launch = ecnt + 1;
    step();
    start = 1'b0;
    repeat (24) step();
    chk("pre_rst_s_wren", int'(s_wren), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("post_rst_fsm_on", int'(fsm_on), 0);
    chk("post_rst_s_wren", int'(s_wren), 0);
    chk("post_rst_pt_wren", int'(pt_wren), 0);
    repeat (5) step();
    for (int a = 0; a < 256; a++) stim_s[a] = 8'($urandom_range(0, 255));
    load_s();
    run_once(launch, fin1);
    chk("after_rst_fin_edge", fin1, launch + 10 * L);

    // Mid-run start pulses are ignored
    start = 1'b1;
    launch = ecnt + 1;
    step();
    start = 1'b0;
    repeat (50) step();
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    wait_fin(fin1);
    chk("pulse_fin_edge", fin1, launch + 10 * L);
    step();
    step();

    // Start held high: back-to-back runs with one IDLE cycle between
    start = 1'b1;
    launch = ecnt + 1;
    wait_fin(fin1);
    chk("b2b_fin1_edge", fin1, launch + 10 * L);
    step();
    chk("b2b_idle_gap", int'(fsm_on), 0);
    step();
    chk("b2b_relaunch", int'(fsm_on), 1);
    wait_fin(fin2);
    chk("b2b_fin2_edge", fin2, fin1 + 2 + 10 * L);
    start = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
